// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// All outputs are registered; tx_end pulses on the final clock of the last stop bit.
module uart_tx_serializer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] data_tx,
  output logic       tx,
  output logic       tx_end,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;

  logic baud_last;
  logic frame_done;
  logic accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  // The last stop-bit edge doubles as an acceptance edge so frames can run back-to-back.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    end_d   = 1'b0;
    busy_d  = busy_q;

    baud_last  = (baud_q == BAUD_LAST);
    frame_done = (state_q == STOP) && baud_last && (bit_q == STOP_LAST);
    accept     = tx_en && ((state_q == IDLE) || frame_done);

    if (state_q != IDLE) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if ((baud_q == BAUD_PRE) && (bit_q == STOP_LAST)) begin
          end_d = 1'b1;
        end
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = data_tx;
      par_d   = (^data_tx) ^ (PARITY_ODD != 0);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  assign tx     = tx_q;
  assign tx_end = end_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (8N1, 8E1, 8O1, 8E2) checked cycle by cycle
// against a frame model built from the line format (start, data LSB-first, parity, stop).
module tb_uart_tx_serializer;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] tx_en;
  logic [7:0] data_tx [4];
  logic [3:0] tx;
  logic [3:0] tx_end;
  logic [3:0] busy;

  int vectors = 0;
  int miscompares = 0;

  int cfg_pe [4] = '{0, 1, 1, 1};
  int cfg_po [4] = '{0, 0, 1, 0};
  int cfg_sb [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst(rst[0]), .tx_en(tx_en[0]), .data_tx(data_tx[0]), .tx(tx[0]), .tx_end(tx_end[0]), .busy(busy[0]));
  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst[1]), .tx_en(tx_en[1]), .data_tx(data_tx[1]), .tx(tx[1]), .tx_end(tx_end[1]), .busy(busy[1]));
  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst(rst[2]), .tx_en(tx_en[2]), .data_tx(data_tx[2]), .tx(tx[2]), .tx_end(tx_end[2]), .busy(busy[2]));
  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_8e2 (.clk(clk), .rst(rst[3]), .tx_en(tx_en[3]), .data_tx(data_tx[3]), .tx(tx[3]), .tx_end(tx_end[3]), .busy(busy[3]));

  function automatic int frame_clks(int d);
    return (10 + cfg_pe[d] + cfg_sb[d] - 1) * CPB;
  endfunction

  // Expected line level k clocks after the acceptance edge, from the frame layout alone.
  function automatic logic exp_tx(int d, logic [7:0] b, int k);
    int pos = k / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (cfg_pe[d] != 0 && pos == 9) return (^b) ^ (cfg_po[d] != 0);
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [2:0] got;
    rst = 4'hF;
    tx_en = 4'h0;
    for (int i = 0; i < 4; i++) data_tx[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 4'h0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        got = {tx[d], busy[d], tx_end[d]};
        vectors++;
        if (got !== 3'b100) begin
          miscompares++;
          $display("FAIL reset_idle dut=%0d cyc=%0d tx/busy/end got=%b want=100", d, c, got);
        end
      end
    end
  endtask

  task automatic test_frame(int d, logic [7:0] b);
    int n = frame_clks(d);
    logic [2:0] got, want;
    @(negedge clk);
    tx_en[d] = 1'b1;
    data_tx[d] = b;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      want = (k < n) ? {exp_tx(d, b, k), 1'b1, (k == n - 1)} : 3'b100;
      got = {tx[d], busy[d], tx_end[d]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL frame dut=%0d byte=%h k=%0d tx/busy/end got=%b want=%b", d, b, k, got, want);
      end
      tx_en[d] = 1'b0;
      data_tx[d] = 8'($urandom);
    end
  endtask

  task automatic test_back_to_back();
    int d = 3;
    int n = frame_clks(d);
    logic [7:0] bytes [3];
    logic [2:0] got, want;
    int f, kk;
    bytes[0] = 8'h55;
    bytes[1] = 8'hAA;
    bytes[2] = 8'($urandom);
    @(negedge clk);
    tx_en[d] = 1'b1;
    data_tx[d] = bytes[0];
    for (int k = 0; k <= 3 * n; k++) begin
      @(negedge clk);
      f = k / n;
      kk = k % n;
      want = (k < 3 * n) ? {exp_tx(d, bytes[f], kk), 1'b1, (kk == n - 1)} : 3'b100;
      got = {tx[d], busy[d], tx_end[d]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back frame=%0d k=%0d tx/busy/end got=%b want=%b", f, kk, got, want);
      end
      tx_en[d] = (kk == n - 1) && (f < 2);
      data_tx[d] = tx_en[d] ? bytes[f+1] : 8'($urandom);
    end
  endtask

  task automatic test_busy_ignore();
    int d = 0;
    int n = frame_clks(d);
    int ends = 0;
    logic [7:0] b = 8'($urandom);
    logic [2:0] got, want;
    @(negedge clk);
    tx_en[d] = 1'b1;
    data_tx[d] = b;
    for (int k = 0; k <= n + 20; k++) begin
      @(negedge clk);
      want = (k < n) ? {exp_tx(d, b, k), 1'b1, (k == n - 1)} : 3'b100;
      got = {tx[d], busy[d], tx_end[d]};
      if (tx_end[d] === 1'b1) ends++;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL busy_ignore byte=%h k=%0d tx/busy/end got=%b want=%b", b, k, got, want);
      end
      tx_en[d] = (k == 29);
      data_tx[d] = (k == 29) ? 8'hFF : 8'($urandom);
    end
    vectors++;
    if (ends != 1) begin
      miscompares++;
      $display("FAIL busy_ignore_end_count got=%0d want=1", ends);
    end
  endtask

  task automatic test_reset_mid();
    int d = 1;
    int ends = 0;
    logic [7:0] b = 8'($urandom);
    logic [2:0] got, want;
    @(negedge clk);
    tx_en[d] = 1'b1;
    data_tx[d] = b;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      want = (k < 45) ? {exp_tx(d, b, k), 1'b1, 1'b0} : 3'b100;
      got = {tx[d], busy[d], tx_end[d]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid k=%0d tx/busy/end got=%b want=%b", k, got, want);
      end
      tx_en[d] = 1'b0;
      rst[d] = (k == 44);
    end
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      got = {tx[d], busy[d], tx_end[d]};
      if (tx_end[d] === 1'b1) ends++;
      vectors++;
      if (got !== 3'b100) begin
        miscompares++;
        $display("FAIL reset_mid_idle cyc=%0d tx/busy/end got=%b want=100", c, got);
      end
    end
    vectors++;
    if (ends != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_end got=%0d want=0", ends);
    end
    test_frame(d, 8'($urandom));
  endtask

  // Upstream model: a 128-bit word drained MSB byte first, next byte offered on each tx_end.
  task automatic test_upstream();
    int d = 0;
    int n = frame_clks(d);
    logic [127:0] word = 128'h000102030405060708090A0B0C0D0E0F;
    int sent = 0, ends = 0, start = 0, cyc = 0, k;
    bit done = 0;
    logic [7:0] cur;
    logic [2:0] got, want;
    @(negedge clk);
    tx_en[d] = 1'b1;
    data_tx[d] = word[127 -: 8];
    sent = 1;
    cur = word[127 -: 8];
    while (!done && cyc < 16 * n + 40) begin
      @(negedge clk);
      k = cyc - start;
      want = (k < n) ? {exp_tx(d, cur, k), 1'b1, (k == n - 1)} : 3'b100;
      got = {tx[d], busy[d], tx_end[d]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL upstream byte=%h k=%0d tx/busy/end got=%b want=%b", cur, k, got, want);
      end
      tx_en[d] = 1'b0;
      if (tx_end[d] === 1'b1) begin
        ends++;
        if (sent < 16) begin
          cur = word[127 - 8 * sent -: 8];
          tx_en[d] = 1'b1;
          data_tx[d] = cur;
          sent++;
          start = cyc + 1;
        end
      end
      if (ends >= 16 && k >= n) done = 1;
      cyc++;
    end
    vectors++;
    if (!done || ends != 16 || sent != 16) begin
      miscompares++;
      $display("FAIL upstream_drain ends=%0d sent=%0d done=%0d want 16/16/1", ends, sent, done);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_frame(0, 8'hA5);
    test_frame(0, 8'($urandom));
    test_frame(0, 8'($urandom));
    test_frame(1, 8'h07);
    test_frame(2, 8'h07);
    test_frame(1, 8'($urandom));
    test_frame(2, 8'($urandom));
    test_frame(3, 8'($urandom));
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_upstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
